// File: rtl/csi2_pkt_tx.sv
// rtl/csi2_pkt_tx.sv - CSI-2 transmit packet builder: header with ECC, payload forwarding, CRC-16 footer
module csi2_pkt_tx #(
    parameter int SHORT_DT_MAX = 15,
    parameter bit CRC_EN       = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_vc_i,
    input  logic [5:0]  req_dt_i,
    input  logic [15:0] req_wc_i,
    input  logic        pl_valid_i,
    output logic        pl_ready_o,
    input  logic [31:0] pl_data_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] data_o,
    output logic [3:0]  keep_o,
    output logic        last_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PAYLOAD = 2'd1;
    localparam logic [1:0] S_FOOTER  = 2'd2;

    localparam logic [5:0] SHORT_MAX = 6'(SHORT_DT_MAX);

    logic [1:0]  state_q, state_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] crc_q, crc_d;
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  keep_q, keep_d;
    logic        last_q, last_d;

    logic        adv;
    logic        req_fire;
    logic        pl_fire;
    logic [23:0] hdr;
    logic [3:0]  pl_keep;
    logic [15:0] pl_bytes;

    function automatic logic [5:0] hdr_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    // Reflected CRC-16 (0x8408), bytes with keep set, byte 0 and bit 0 first.
    function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [31:0] w,
                                             input logic [3:0] k);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int b = 0; b < 4; b++) begin
            if (k[b]) begin
                for (int i = 0; i < 8; i++) begin
                    fb = r[0] ^ w[8*b+i];
                    r  = {1'b0, r[15:1]};
                    if (fb) r = r ^ 16'h8408;
                end
            end
        end
        return r;
    endfunction

    assign adv         = !valid_q || ready_i;
    assign req_ready_o = !rst_i && (state_q == S_IDLE) && adv;
    assign pl_ready_o  = !rst_i && (state_q == S_PAYLOAD) && adv;
    assign req_fire    = req_valid_i && req_ready_o;
    assign pl_fire     = pl_valid_i && pl_ready_o;
    assign hdr         = {req_wc_i, req_vc_i, req_dt_i};

    always_comb begin
        pl_keep  = 4'hF;
        pl_bytes = 16'd4;
        if (rem_q < 16'd4) begin
            pl_bytes = rem_q;
            case (rem_q[1:0])
                2'd1:    pl_keep = 4'h1;
                2'd2:    pl_keep = 4'h3;
                2'd3:    pl_keep = 4'h7;
                default: pl_keep = 4'h0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        crc_d   = crc_q;
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    valid_d = 1'b1;
                    data_d  = {2'b00, hdr_ecc(hdr), hdr};
                    keep_d  = 4'hF;
                    rem_d   = req_wc_i;
                    crc_d   = 16'hFFFF;
                    if (req_dt_i <= SHORT_MAX) begin
                        last_d = 1'b1;
                    end else if (req_wc_i == 16'd0) begin
                        last_d  = 1'b0;
                        state_d = S_FOOTER;
                    end else begin
                        last_d  = 1'b0;
                        state_d = S_PAYLOAD;
                    end
                end else if (adv) begin
                    valid_d = 1'b0;
                end
            end
            S_PAYLOAD: begin
                if (pl_fire) begin
                    valid_d = 1'b1;
                    data_d  = pl_data_i;
                    keep_d  = pl_keep;
                    last_d  = 1'b0;
                    rem_d   = rem_q - pl_bytes;
                    crc_d   = CRC_EN ? crc_word(crc_q, pl_data_i, pl_keep) : crc_q;
                    if (rem_q <= 16'd4) state_d = S_FOOTER;
                end else if (adv) begin
                    valid_d = 1'b0;
                end
            end
            S_FOOTER: begin
                if (adv) begin
                    valid_d = 1'b1;
                    data_d  = {16'h0000, (CRC_EN ? crc_q : 16'h0000)};
                    keep_d  = 4'h3;
                    last_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            rem_q   <= 16'd0;
            crc_q   <= 16'hFFFF;
            valid_q <= 1'b0;
            data_q  <= 32'd0;
            keep_q  <= 4'h0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            crc_q   <= crc_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;

endmodule
